tib_loader: RTL

- Upstream feeder for the eJ32 outer interpreter.
- Receives serial console characters on a UART RX line, edits them into a line, and writes the bytes into the terminal input buffer (TIB) region of the shared 8-bit byte memory.
- On end-of-line it writes a 0x00 terminator, then hands the line to eJ32 with a ready/ack handshake.
- Shares the byte memory with eJ32 through a grant-based write port.

---
 rtl/tib_loader_pkg.sv | 26 ++
 rtl/tib_loader_if.sv | 20 ++
 rtl/tib_loader_uart_rx.sv | 103 ++++++++++
 rtl/tib_loader.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tib_loader_pkg.sv
// Shared types and constants for the TIB line loader.
package tib_loader_pkg;

  typedef enum logic [1:0] {L_IDLE, L_WR, L_TERM, L_RDY} tib_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {C_EOL, C_ERASE, C_PRINT} char_class_t;

  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_DEL = 8'h7F;
  localparam logic [7:0] ASC_SPC = 8'h20;

  // Line-editing role of a received character.
  function automatic char_class_t classify(input logic [7:0] c);
    if (c == ASC_CR || c == ASC_LF) return C_EOL;
    if (c == ASC_BS || c == ASC_DEL) return C_ERASE;
    return C_PRINT;
  endfunction

  // Control characters that are not edit commands are stored as spaces.
  function automatic logic [7:0] sanitize(input logic [7:0] c);
    return (c < ASC_SPC) ? ASC_SPC : c;
  endfunction

endpackage

// File: rtl/tib_loader_if.sv
// Memory write port and line handoff between the loader and eJ32.
interface tib_loader_if #(parameter int ASZ = 17);
  logic           mem_we;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_data;
  logic           mem_gnt;
  logic           line_rdy;
  logic [ASZ-1:0] line_len;
  logic           line_ack;

  modport master (
    output mem_we, mem_addr, mem_data, line_rdy, line_len,
    input  mem_gnt, line_ack
  );

  modport slave (
    input  mem_we, mem_addr, mem_data, line_rdy, line_len,
    output mem_gnt, line_ack
  );
endinterface

// File: rtl/tib_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, down-counting bit timer, LSB-first shifter.
module uart_rx
  import tib_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       ferr
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);

  rx_state_t     state, state_nxt;
  logic [2:0]    sync;
  logic [CW-1:0] cnt, cnt_val;
  logic          cnt_ld;
  logic [2:0]    bitn;
  logic          shift;
  logic          rx_s, fall, tick;

  // sync[1] is the synchronised line; sync[2] its previous value for edge detect.
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign tick = (cnt == '0);

  // Synchroniser chain, idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b111;
    else        sync <= {sync[1:0], rx};
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= R_IDLE;
    else        state <= state_nxt;
  end

  // Next state, timer reloads and sample strobes.
  always_comb begin
    state_nxt = state;
    cnt_ld    = 1'b0;
    cnt_val   = BIT_LD;
    shift     = 1'b0;
    byte_vld  = 1'b0;
    ferr      = 1'b0;
    case (state)
      R_IDLE: begin
        if (fall) begin
          state_nxt = R_START;
          cnt_ld    = 1'b1;
          cnt_val   = HALF_LD;
        end
      end
      R_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_nxt = R_DATA;
            cnt_ld    = 1'b1;
          end else begin
            state_nxt = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          shift  = 1'b1;
          cnt_ld = 1'b1;
          if (bitn == 3'd7) state_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (tick) begin
          state_nxt = R_IDLE;
          if (rx_s) byte_vld = 1'b1;
          else      ferr     = 1'b1;
        end
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  // Bit timer, bit index and data shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bitn    <= '0;
      rx_byte <= '0;
    end else begin
      if (cnt_ld)    cnt <= cnt_val;
      else if (!tick) cnt <= cnt - 1'b1;
      if (state == R_START) bitn <= '0;
      else if (shift)       bitn <= bitn + 3'd1;
      if (shift) rx_byte <= {rx_s, rx_byte[7:1]};
    end
  end

endmodule

// File: rtl/tib_loader.sv
// Edits UART characters into a line in the TIB and hands it to eJ32.
//
// state  | meaning
// L_IDLE | classify the pending byte, if any
// L_WR   | writing a printable byte at TIB+len, waiting for grant
// L_TERM | writing the 0x00 terminator at TIB+len, waiting for grant
// L_RDY  | line complete, waiting for line_ack; incoming bytes dropped
module tib_loader
  import tib_loader_pkg::*;
#(
  parameter int TIB    = 'h1000,
  parameter int TIB_SZ = 'h100,
  parameter int ASZ    = 17,
  parameter int DIV    = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  tib_loader_if.master      bus,
  output logic              ovf,
  output logic              ferr
);

  localparam logic [ASZ-1:0] LEN_MAX  = ASZ'(TIB_SZ - 1);
  localparam logic [ASZ-1:0] TIB_BASE = ASZ'(TIB);

  tib_state_t     state, state_nxt;
  logic [ASZ-1:0] len, len_nxt;
  logic [7:0]     wr_byte, wr_nxt;
  logic           pend_full;
  logic [7:0]     pend_byte;
  logic           take, drop, clr, accept;
  logic           byte_vld;
  logic [7:0]     rx_byte;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .ferr     (ferr)
  );

  // Line FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= L_IDLE;
    else        state <= state_nxt;
  end

  // Next state, line length update, byte drops and memory/handoff outputs.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    wr_nxt    = wr_byte;
    take      = 1'b0;
    drop      = 1'b0;
    clr       = 1'b0;
    case (state)
      L_IDLE: begin
        if (pend_full) begin
          take = 1'b1;
          case (classify(pend_byte))
            C_EOL: begin
              // Empty line ignored, so CR-LF yields one terminator.
              if (len != '0) state_nxt = L_TERM;
            end
            C_ERASE: begin
              if (len != '0) len_nxt = len - ASZ'(1);
            end
            default: begin
              if (len < LEN_MAX) begin
                wr_nxt    = sanitize(pend_byte);
                state_nxt = L_WR;
              end else begin
                drop = 1'b1;
              end
            end
          endcase
        end
      end
      L_WR: begin
        if (bus.mem_gnt) begin
          len_nxt   = len + ASZ'(1);
          state_nxt = L_IDLE;
        end
      end
      L_TERM: begin
        if (bus.mem_gnt) state_nxt = L_RDY;
      end
      L_RDY: begin
        take = pend_full;
        drop = pend_full | byte_vld;
        if (bus.line_ack) begin
          state_nxt = L_IDLE;
          len_nxt   = '0;
          clr       = 1'b1;
        end
      end
      default: state_nxt = L_IDLE;
    endcase

    // A byte arriving while the holding register stays full is lost.
    accept = byte_vld && (state != L_RDY) && (!pend_full || take);
    if (byte_vld && (state != L_RDY) && pend_full && !take) drop = 1'b1;

    bus.mem_we   = (state == L_WR) || (state == L_TERM);
    bus.mem_addr = bus.mem_we ? (TIB_BASE + len) : '0;
    bus.mem_data = (state == L_WR) ? wr_byte : 8'h00;
    bus.line_rdy = (state == L_RDY);
    bus.line_len = (state == L_RDY) ? len : '0;
  end

  // Line length, write byte, holding register and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      wr_byte   <= '0;
      pend_full <= 1'b0;
      pend_byte <= '0;
      ovf       <= 1'b0;
    end else begin
      len     <= len_nxt;
      wr_byte <= wr_nxt;
      if (accept) begin
        pend_full <= 1'b1;
        pend_byte <= rx_byte;
      end else if (take) begin
        pend_full <= 1'b0;
      end
      if (clr)       ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

endmodule
